corr_segment_scheduler: RTL and testbench
=========================================

# corr_segment_scheduler

Top-level sequencer for the fast Fourier correlator. It computes the reference spectrum once by starting the F1 reader/FFT path. It then walks the long signal F2 in overlap-save segments of NFFT samples, issuing one start per segment with its read offset, length and output-lag window. It keeps up to MAX_OUT segments in flight, ahead of the multiply/IFFT/output path, and signals completion when every lag has been produced.

## Interface
- NFFT, 256: FFT length; power of two, 16..4096.
- MAX_OUT, 2: maximum segments issued but not yet retired (1..4).

- aclk  in  1  system clock, all logic on rising edge.
- aresetn  in  1  synchronous reset, active low.
- go  in  1  one-cycle request to start a correlation; ignored while busy=1.
- N1  in  13  length of F1 (reference), sampled on accepted go.
- N2  in  16  length of F2 (long signal), sampled on accepted go.
- f1_start  out  1  one-cycle pulse: start F1 read and FFT.
- f1_done  in  1  one-cycle pulse: F1 spectrum stored.
- seg_start  out  1  one-cycle pulse: start one F2 segment.
- seg_offset  out  16  first F2 sample index of the segment.
- seg_len  out  13  F2 samples to read; the reader zero-pads to NFFT.
- lag_base  out  16  first correlation lag produced by this segment.
- lag_count  out  13  valid IFFT outputs to keep (indices 0..lag_count-1).
- seg_retire  in  1  one-cycle pulse: downstream finished one segment's output.
- busy  out  1  high from accepted go until done/err.
- done  out  1  one-cycle pulse: all segments retired.
- err  out  1  one-cycle pulse: parameters rejected.
- proto_err  out  1  one-cycle pulse: seg_retire with nothing outstanding.

## Operation
- States: IDLE, CHECK, LOAD_F1, ISSUE, DRAIN.
- IDLE: on go, latch N1/N2 and go to CHECK; busy=1 from the next cycle.
- CHECK (1 cycle): valid iff 1<=N1<=NFFT and N2>=N1.
  - If invalid: err pulse, then IDLE.
  - If valid: register step=NFFT-N1+1 and lags_left=N2-N1+1 (17 bit); clear offset, lag_base and outstanding; go to LOAD_F1 with a f1_start pulse on entry.
- LOAD_F1: wait for f1_done, then go to ISSUE. f1_done in any other state is ignored.
- ISSUE: when outstanding<MAX_OUT and lags_left>0, pulse seg_start and drive:
  - seg_offset=offset; seg_len=min(NFFT, N2-offset).
  - lag_count=min(step, lags_left); lag_base=offset.
  - Next cycle: offset+=step, lags_left-=lag_count, outstanding+=1.
  - Enter DRAIN when lags_left reaches 0.
- DRAIN: wait for outstanding==0, then done pulse and IDLE; busy drops in the same cycle as done.
- outstanding bookkeeping:
  - seg_retire decrements it in any state.
  - seg_start and seg_retire in the same cycle leave it unchanged.
  - seg_retire with outstanding==0 does not change the count and pulses proto_err.
- Arithmetic: unsigned; the min() operands are zero-extended to 17 bits; offset never exceeds N2.
- Segment outputs hold their values until the next seg_start and return to 0 in IDLE.

## Timing
- Reset values: state IDLE, and every output 0 (f1_start, seg_start, seg_offset, seg_len, lag_base, lag_count, busy, done, err, proto_err). Counters are 0.
- go to f1_start: 2 cycles (go at T, CHECK at T+1, f1_start at T+2).
- go to err: 1 cycle.
- f1_done at T: first seg_start at T+1.
- Back-to-back segments: one seg_start every 2 cycles while credit is available (issue cycle, then update cycle).
- Credit return: a seg_retire at T that frees credit allows seg_start at T+1.
- Last retire at T: done at T+1.
- go asserted while busy: ignored entirely, no latch and no err.
- Reset mid-operation: immediate return to IDLE with all outputs 0; pending pulses are dropped.

## Test plan
- NFFT=256, N1=57, N2=1000, MAX_OUT=2, seg_retire 20 cycles after each seg_start:
  - Exactly 5 seg_start pulses.
  - Offsets 0/200/400/600/800; seg_len 256,256,256,256,200; lag_count 200,200,200,200,144.
  - done follows the 5th retire by 1 cycle.
- Withhold seg_retire: exactly 2 seg_start pulses, then stall. Release one retire: the 3rd seg_start appears the next cycle.
- N1=256, N2=256: step=1, one segment with offset 0, seg_len 256, lag_count 1, then done.
- Invalid parameters each give err 1 cycle after go, with no f1_start and busy low afterwards:
  - N1=0.
  - N1=300.
  - N1=100 with N2=50.
- seg_retire while idle gives a proto_err pulse and no state change.
- Simultaneous seg_start and seg_retire leave outstanding unchanged.
- aresetn low during DRAIN returns all outputs to 0; a following go=1 with valid parameters restarts cleanly (f1_start after 2 cycles).

Source files
------------

// File: rtl/corr_segment_scheduler.sv
// Top-level sequencer for the fast Fourier correlator: loads the reference
// spectrum once, then issues overlap-save segments of the long signal with credit control.
module corr_segment_scheduler #(
    parameter int NFFT    = 256,
    parameter int MAX_OUT = 2
) (
    input  logic        aclk_i,
    input  logic        aresetn_i,
    input  logic        go_i,
    input  logic [12:0] n1_i,
    input  logic [15:0] n2_i,
    output logic        f1_start_o,
    input  logic        f1_done_i,
    output logic        seg_start_o,
    output logic [15:0] seg_offset_o,
    output logic [12:0] seg_len_o,
    output logic [15:0] lag_base_o,
    output logic [12:0] lag_count_o,
    input  logic        seg_retire_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        proto_err_o
);

    localparam logic [16:0] NFFT17  = 17'(NFFT);
    localparam logic [2:0]  MAXOUT3 = 3'(MAX_OUT);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        LOAD_F1,
        ISSUE,
        DRAIN
    } state_t;

    state_t      state_q;
    logic [12:0] n1_q;
    logic [15:0] n2_q;
    logic [16:0] step_q;
    logic [16:0] lagsLeft_q;
    logic [16:0] offset_q;
    logic [2:0]  outstanding_q;

    logic        f1Start_q;
    logic        segStart_q;
    logic [15:0] segOffset_q;
    logic [12:0] segLen_q;
    logic [15:0] lagBase_q;
    logic [12:0] lagCount_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic        protoErr_q;

    logic        retireOk;
    logic [2:0]  outAfterRetire;
    logic        canIssue;
    logic        issueNow;
    logic [16:0] availLen;
    logic [16:0] segLen_d;
    logic [16:0] lagCount_d;
    logic [16:0] offsetSum;
    logic [16:0] offset_d;
    logic [16:0] lagsLeft_d;
    logic [16:0] step_d;
    logic [16:0] lagsInit_d;
    logic        goValid;
    logic        checkValid;

    function automatic logic paramsOk(input logic [12:0] n1, input logic [15:0] n2);
        return (n1 != 13'd0) && ({4'b0, n1} <= NFFT17) && (n2 >= {3'b0, n1});
    endfunction

    // Segment geometry and credit for the next issue; a retire seen this
    // cycle already frees its credit so the next segment can go out at once.
    always_comb begin
        retireOk       = seg_retire_i && (outstanding_q != 3'd0);
        outAfterRetire = outstanding_q - {2'b0, retireOk};
        availLen       = {1'b0, n2_q} - offset_q;
        segLen_d       = (availLen < NFFT17) ? availLen : NFFT17;
        lagCount_d     = (step_q < lagsLeft_q) ? step_q : lagsLeft_q;
        offsetSum      = offset_q + step_q;
        offset_d       = (offsetSum > {1'b0, n2_q}) ? {1'b0, n2_q} : offsetSum;
        lagsLeft_d     = lagsLeft_q - lagCount_d;
        step_d         = NFFT17 - {4'b0, n1_q} + 17'd1;
        lagsInit_d     = {1'b0, n2_q} - {4'b0, n1_q} + 17'd1;
        goValid        = paramsOk(n1_i, n2_i);
        checkValid     = paramsOk(n1_q, n2_q);
        canIssue       = (outAfterRetire < MAXOUT3) && (lagsLeft_q != 17'd0) && !segStart_q;
        issueNow       = canIssue && (((state_q == LOAD_F1) && f1_done_i) || (state_q == ISSUE));
    end

    always_ff @(posedge aclk_i) begin
        if (!aresetn_i) begin
            state_q       <= IDLE;
            n1_q          <= '0;
            n2_q          <= '0;
            step_q        <= '0;
            lagsLeft_q    <= '0;
            offset_q      <= '0;
            outstanding_q <= '0;
            f1Start_q     <= 1'b0;
            segStart_q    <= 1'b0;
            segOffset_q   <= '0;
            segLen_q      <= '0;
            lagBase_q     <= '0;
            lagCount_q    <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            protoErr_q    <= 1'b0;
        end else begin
            f1Start_q     <= 1'b0;
            segStart_q    <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            protoErr_q    <= seg_retire_i && (outstanding_q == 3'd0);
            outstanding_q <= outAfterRetire + {2'b0, issueNow};

            if (issueNow) begin
                segStart_q  <= 1'b1;
                segOffset_q <= 16'(offset_q);
                segLen_q    <= 13'(segLen_d);
                lagBase_q   <= 16'(offset_q);
                lagCount_q  <= 13'(lagCount_d);
                offset_q    <= offset_d;
                lagsLeft_q  <= lagsLeft_d;
            end

            case (state_q)
                IDLE: begin
                    if (go_i) begin
                        n1_q    <= n1_i;
                        n2_q    <= n2_i;
                        busy_q  <= 1'b1;
                        err_q   <= !goValid;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (checkValid) begin
                        step_q        <= step_d;
                        lagsLeft_q    <= lagsInit_d;
                        offset_q      <= '0;
                        outstanding_q <= '0;
                        f1Start_q     <= 1'b1;
                        state_q       <= LOAD_F1;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                LOAD_F1: begin
                    if (issueNow) begin
                        state_q <= (lagsLeft_d == 17'd0) ? DRAIN : ISSUE;
                    end
                end
                ISSUE: begin
                    if (issueNow && (lagsLeft_d == 17'd0)) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Segment fields read as zero again once the job is finished.
                    if (outAfterRetire == 3'd0) begin
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        segOffset_q <= '0;
                        segLen_q    <= '0;
                        lagBase_q   <= '0;
                        lagCount_q  <= '0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign f1_start_o   = f1Start_q;
    assign seg_start_o  = segStart_q;
    assign seg_offset_o = segOffset_q;
    assign seg_len_o    = segLen_q;
    assign lag_base_o   = lagBase_q;
    assign lag_count_o  = lagCount_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign proto_err_o  = protoErr_q;

endmodule

// File: tb/tb_corr_segment_scheduler.sv
// Scoreboard bench for corr_segment_scheduler: expected segments are queued
// when a job is started and popped as seg_start pulses appear.
module tb_corr_segment_scheduler;

    logic        aclk;
    logic        aresetn;
    logic        go_i;
    logic [12:0] n1_i;
    logic [15:0] n2_i;
    logic        f1_start_o;
    logic        f1_done_i;
    logic        seg_start_o;
    logic [15:0] seg_offset_o;
    logic [12:0] seg_len_o;
    logic [15:0] lag_base_o;
    logic [12:0] lag_count_o;
    logic        seg_retire_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic        proto_err_o;

    typedef struct {
        int off;
        int len;
        int base;
        int cnt;
    } seg_t;

    seg_t expQ[$];
    int   dueQ[$];
    int   totalChecks = 0;
    int   badChecks = 0;
    int   cyc = 0;
    int   retireDelay = 0;
    int   startCount = 0;
    int   lastRetireCyc = -100;
    int   doneCyc = 0;
    int   doneSeen = 0;
    int   busyAtDone = 0;
    logic prevStart = 1'b0;

    corr_segment_scheduler #(
        .NFFT(256),
        .MAX_OUT(2)
    ) dut (
        .aclk_i(aclk),
        .aresetn_i(aresetn),
        .go_i(go_i),
        .n1_i(n1_i),
        .n2_i(n2_i),
        .f1_start_o(f1_start_o),
        .f1_done_i(f1_done_i),
        .seg_start_o(seg_start_o),
        .seg_offset_o(seg_offset_o),
        .seg_len_o(seg_len_o),
        .lag_base_o(lag_base_o),
        .lag_count_o(lag_count_o),
        .seg_retire_i(seg_retire_i),
        .busy_o(busy_o),
        .done_o(done_o),
        .err_o(err_o),
        .proto_err_o(proto_err_o)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        totalChecks++;
        if (actual !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    // Per-cycle monitor: drives due retires and scores any issued segment.
    task automatic sampleCycle();
        seg_t e;
        seg_retire_i = 1'b0;
        for (int i = 0; i < dueQ.size(); i++) begin
            if (dueQ[i] == cyc) begin
                dueQ.delete(i);
                seg_retire_i  = 1'b1;
                lastRetireCyc = cyc;
                break;
            end
        end
        if (seg_start_o) begin
            startCount++;
            checkOutput("segGap", int'(prevStart), 0);
            if (expQ.size() == 0) begin
                checkOutput("unexpectedSeg", int'(seg_start_o), 0);
            end else begin
                e = expQ.pop_front();
                checkOutput("segOffset", int'(seg_offset_o), e.off);
                checkOutput("segLen", int'(seg_len_o), e.len);
                checkOutput("lagBase", int'(lag_base_o), e.base);
                checkOutput("lagCount", int'(lag_count_o), e.cnt);
            end
            if (retireDelay > 0) dueQ.push_back(cyc + retireDelay);
        end
        if (done_o && !doneSeen) begin
            doneSeen   = 1;
            doneCyc    = cyc;
            busyAtDone = int'(busy_o);
        end
        prevStart = seg_start_o;
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
        cyc++;
        sampleCycle();
    endtask

    task automatic pushMain();
        expQ.push_back('{0, 256, 0, 200});
        expQ.push_back('{200, 256, 200, 200});
        expQ.push_back('{400, 256, 400, 200});
        expQ.push_back('{600, 256, 600, 200});
        expQ.push_back('{800, 200, 800, 144});
    endtask

    task automatic pushSingle();
        expQ.push_back('{0, 256, 0, 1});
    endtask

    // Starts a valid job and checks the go/f1_start/f1_done timing.
    task automatic applyStimulus(input int n1, input int n2);
        startCount = 0;
        doneSeen   = 0;
        go_i = 1'b1;
        n1_i = 13'(n1);
        n2_i = 16'(n2);
        tick();
        go_i = 1'b0;
        checkOutput("busyInCheck", int'(busy_o), 1);
        checkOutput("f1EarlyStart", int'(f1_start_o), 0);
        tick();
        checkOutput("f1StartLat", int'(f1_start_o), 1);
        tick();
        checkOutput("f1StartPulse", int'(f1_start_o), 0);
        tick();
        checkOutput("noSegBeforeF1", int'(seg_start_o), 0);
        f1_done_i = 1'b1;
        tick();
        f1_done_i = 1'b0;
        checkOutput("firstSegLat", int'(seg_start_o), 1);
    endtask

    task automatic serviceLoop(input int expStarts, input int maxCycles);
        int n;
        n = 0;
        while (!doneSeen && n < maxCycles) begin
            tick();
            n++;
        end
        checkOutput("doneSeen", doneSeen, 1);
        if (doneSeen) begin
            checkOutput("doneLat", doneCyc - lastRetireCyc, 1);
            checkOutput("busyAtDone", busyAtDone, 0);
        end
        checkOutput("startCount", startCount, expStarts);
        checkOutput("queueEmpty", expQ.size(), 0);
        checkOutput("protoQuiet", int'(proto_err_o), 0);
        tick();
        checkOutput("segClearOff", int'(seg_offset_o), 0);
        checkOutput("segClearLen", int'(seg_len_o), 0);
        checkOutput("busyIdle", int'(busy_o), 0);
    endtask

    task automatic badJob(input int n1, input int n2);
        go_i = 1'b1;
        n1_i = 13'(n1);
        n2_i = 16'(n2);
        tick();
        go_i = 1'b0;
        checkOutput("errLat", int'(err_o), 1);
        checkOutput("errNoF1", int'(f1_start_o), 0);
        tick();
        checkOutput("errPulse", int'(err_o), 0);
        checkOutput("errBusyLow", int'(busy_o), 0);
        checkOutput("errNoF1Late", int'(f1_start_o), 0);
        tick();
        checkOutput("errNoF1Later", int'(f1_start_o), 0);
    endtask

    initial begin
        aresetn      = 1'b0;
        go_i         = 1'b0;
        n1_i         = '0;
        n2_i         = '0;
        f1_done_i    = 1'b0;
        seg_retire_i = 1'b0;
        repeat (3) tick();
        checkOutput("rstBusy", int'(busy_o), 0);
        checkOutput("rstF1", int'(f1_start_o), 0);
        checkOutput("rstSeg", int'(seg_start_o), 0);
        checkOutput("rstLen", int'(seg_len_o), 0);
        checkOutput("rstErr", int'(err_o), 0);
        checkOutput("rstDone", int'(done_o), 0);
        aresetn = 1'b1;
        tick();

        // Retire while idle.
        seg_retire_i = 1'b1;
        tick();
        checkOutput("protoErr", int'(proto_err_o), 1);
        checkOutput("protoBusy", int'(busy_o), 0);
        tick();
        checkOutput("protoPulse", int'(proto_err_o), 0);

        // Main job, retire 20 cycles after each start.
        retireDelay = 20;
        pushMain();
        applyStimulus(57, 1000);
        serviceLoop(5, 300);

        // Withheld retires stall after two segments; go while busy is ignored.
        retireDelay = 0;
        pushMain();
        applyStimulus(57, 1000);
        repeat (30) tick();
        checkOutput("withheldStarts", startCount, 2);
        go_i = 1'b1;
        n1_i = 13'd0;
        n2_i = 16'd5;
        tick();
        go_i = 1'b0;
        checkOutput("goIgnoredErr", int'(err_o), 0);
        checkOutput("goIgnoredBusy", int'(busy_o), 1);
        tick();
        checkOutput("goIgnoredF1", int'(f1_start_o), 0);
        seg_retire_i  = 1'b1;
        lastRetireCyc = cyc;
        tick();
        checkOutput("creditReturn", int'(seg_start_o), 1);
        dueQ.push_back(cyc + 3);
        dueQ.push_back(cyc + 5);
        retireDelay = 4;
        serviceLoop(5, 300);

        // Single-segment job: N1 = N2 = NFFT.
        retireDelay = 5;
        pushSingle();
        applyStimulus(256, 256);
        serviceLoop(1, 100);

        // Retire coincides with every later seg_start.
        retireDelay = 2;
        pushMain();
        applyStimulus(57, 1000);
        serviceLoop(5, 200);

        // Invalid parameter sets.
        badJob(0, 100);
        badJob(300, 1000);
        badJob(100, 50);

        // Reset while draining, then a clean restart.
        retireDelay = 0;
        pushSingle();
        applyStimulus(256, 256);
        repeat (3) tick();
        checkOutput("drainBusy", int'(busy_o), 1);
        aresetn = 1'b0;
        tick();
        checkOutput("midRstBusy", int'(busy_o), 0);
        checkOutput("midRstLen", int'(seg_len_o), 0);
        checkOutput("midRstCount", int'(lag_count_o), 0);
        checkOutput("midRstSeg", int'(seg_start_o), 0);
        aresetn = 1'b1;
        dueQ.delete();
        tick();
        retireDelay = 20;
        pushMain();
        applyStimulus(57, 1000);
        serviceLoop(5, 300);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
